// File: rtl/mem_stage_unit.sv
// Memory stage of the 8-bit pipelined MIPS core: it resolves the branch redirect,
// performs loads and stores over a req/ack handshake with a timeout, and registers the MEM/WB fields.
module mem_stage_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] in_new_branch_pc,
  input  logic        in_zero,
  input  logic [7:0]  in_alu_result,
  input  logic [7:0]  in_data_2,
  input  logic [2:0]  in_reg_write,
  input  logic        in_MEM_mem_read_write,
  input  logic        in_MEM_pc_src,
  input  logic        in_WB_mem_or_alu,
  input  logic        in_WB_reg_write_signal,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic        dmem_ack,
  input  logic [7:0]  dmem_rdata,
  output logic        stall,
  output logic        out_pc_src,
  output logic [11:0] out_branch_pc,
  output logic [7:0]  out_mem_data,
  output logic [7:0]  out_alu_result,
  output logic [2:0]  out_reg_write,
  output logic        out_WB_mem_or_alu,
  output logic        out_WB_reg_write_signal,
  output logic        mem_error
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_next;
  logic [7:0] cnt;
  logic       need_access;
  logic       at_limit;

  // A store always touches memory; otherwise only a load (write-back from memory) does.
  assign need_access = in_MEM_mem_read_write | in_WB_mem_or_alu;
  assign at_limit    = (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (need_access)          state_next = S_WAIT;
      S_WAIT: if (dmem_ack || at_limit) state_next = S_IDLE;
      default:                          state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      case (state)
        S_IDLE:  stall = need_access;
        S_WAIT:  stall = !dmem_ack && !at_limit;
        default: stall = 1'b0;
      endcase
    end
    out_pc_src    = rst_n & in_MEM_pc_src & in_zero & !stall;
    out_branch_pc = in_new_branch_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req                <= 1'b0;
      dmem_we                 <= 1'b0;
      dmem_addr               <= 8'h00;
      dmem_wdata              <= 8'h00;
      cnt                     <= 8'h00;
      out_mem_data            <= 8'h00;
      out_alu_result          <= 8'h00;
      out_reg_write           <= 3'd0;
      out_WB_mem_or_alu       <= 1'b0;
      out_WB_reg_write_signal <= 1'b0;
      mem_error               <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (need_access) begin
            dmem_req                <= 1'b1;
            dmem_we                 <= in_MEM_mem_read_write;
            dmem_addr               <= in_alu_result;
            dmem_wdata              <= in_data_2;
            cnt                     <= 8'h00;
            out_WB_mem_or_alu       <= 1'b0;
            out_WB_reg_write_signal <= 1'b0;
          end else begin
            out_alu_result          <= in_alu_result;
            out_reg_write           <= in_reg_write;
            out_WB_mem_or_alu       <= in_WB_mem_or_alu;
            out_WB_reg_write_signal <= in_WB_reg_write_signal;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req                <= 1'b0;
            out_alu_result          <= in_alu_result;
            out_reg_write           <= in_reg_write;
            out_WB_mem_or_alu       <= in_WB_mem_or_alu;
            out_WB_reg_write_signal <= in_WB_reg_write_signal;
            if (!dmem_we) out_mem_data <= dmem_rdata;
          end else if (at_limit) begin
            // Aborted access retires with its register write suppressed.
            dmem_req                <= 1'b0;
            mem_error               <= 1'b1;
            out_alu_result          <= in_alu_result;
            out_reg_write           <= in_reg_write;
            out_WB_mem_or_alu       <= in_WB_mem_or_alu;
            out_WB_reg_write_signal <= 1'b0;
            out_mem_data            <= 8'h00;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: dmem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: a driver predicts each instruction's retirement,
// a monitor compares when the instruction leaves the stage, and a responder models the memory.
module tb_mem_stage_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] in_new_branch_pc = '0;
  logic        in_zero = 1'b0;
  logic [7:0]  in_alu_result = '0;
  logic [7:0]  in_data_2 = '0;
  logic [2:0]  in_reg_write = '0;
  logic        in_MEM_mem_read_write = 1'b0;
  logic        in_MEM_pc_src = 1'b0;
  logic        in_WB_mem_or_alu = 1'b0;
  logic        in_WB_reg_write_signal = 1'b0;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [7:0]  dmem_rdata = '0;
  logic        stall, out_pc_src;
  logic [11:0] out_branch_pc;
  logic [7:0]  out_mem_data, out_alu_result;
  logic [2:0]  out_reg_write;
  logic        out_WB_mem_or_alu, out_WB_reg_write_signal, mem_error;

  mem_stage_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_new_branch_pc(in_new_branch_pc), .in_zero(in_zero),
    .in_alu_result(in_alu_result), .in_data_2(in_data_2),
    .in_reg_write(in_reg_write), .in_MEM_mem_read_write(in_MEM_mem_read_write),
    .in_MEM_pc_src(in_MEM_pc_src), .in_WB_mem_or_alu(in_WB_mem_or_alu),
    .in_WB_reg_write_signal(in_WB_reg_write_signal),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .out_pc_src(out_pc_src), .out_branch_pc(out_branch_pc),
    .out_mem_data(out_mem_data), .out_alu_result(out_alu_result),
    .out_reg_write(out_reg_write), .out_WB_mem_or_alu(out_WB_mem_or_alu),
    .out_WB_reg_write_signal(out_WB_reg_write_signal), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        acc;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        pc_src;
    logic [11:0] bpc;
    int          stalls;
    logic [7:0]  alu;
    logic [2:0]  rd;
    logic        mor;
    logic        sig;
    logic [7:0]  mdata;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  int         lat_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] dev_mem [256];
  logic [7:0] mdl_mdata = 8'h00;
  logic       mdl_err = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one instruction (called at posedge+1), predict its retirement, hold it while stalled.
  task automatic issue(input logic rw, input logic mor, input logic sig,
                       input logic [7:0] alu, input logic [7:0] data, input logic [2:0] rd,
                       input logic br, input logic z, input logic [11:0] pc, input int lat);
    exp_t e;
    logic acc, abort;
    int   n;
    in_MEM_mem_read_write = rw;   in_WB_mem_or_alu = mor;
    in_WB_reg_write_signal = sig; in_alu_result = alu;
    in_data_2 = data;             in_reg_write = rd;
    in_MEM_pc_src = br;           in_zero = z;
    in_new_branch_pc = pc;
    acc   = rw | mor;
    abort = acc && (lat > T);
    e.acc = acc; e.we = rw; e.addr = alu; e.wdata = data;
    e.pc_src = br & z; e.bpc = pc;
    e.stalls = !acc ? 0 : (abort ? T : lat);
    e.alu = alu; e.rd = rd; e.mor = mor; e.sig = abort ? 1'b0 : sig;
    if (abort) begin
      mdl_mdata = 8'h00;
      mdl_err   = 1'b1;
    end else if (acc && !rw) begin
      mdl_mdata = ref_mem[alu];
    end else if (acc && rw) begin
      ref_mem[alu] = data;
    end
    e.mdata = mdl_mdata; e.err = mdl_err;
    sb.push_back(e);
    if (acc) lat_q.push_back(lat);
    n = 0;
    @(negedge clk);
    while (stall && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (stall) check("stall_bound", 32'(stall), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic set_nop();
    in_MEM_mem_read_write = 1'b0; in_WB_mem_or_alu = 1'b0;
    in_WB_reg_write_signal = 1'b0; in_MEM_pc_src = 1'b0; in_zero = 1'b0;
    in_alu_result = '0; in_data_2 = '0; in_reg_write = '0; in_new_branch_pc = '0;
  endtask

  // Memory responder: acks on the lat-th WAIT cycle; lat beyond T means never.
  initial begin
    int wcnt = 0;
    int lat = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        dmem_ack = 1'b0;
        wcnt = 0;
      end else if (dmem_ack) begin
        check("req_drop_after_ack", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;
        wcnt = 0;
      end else if (dmem_req) begin
        if (wcnt == 0) lat = (lat_q.size() > 0) ? lat_q.pop_front() : 100;
        wcnt++;
        if (wcnt == lat) begin
          dmem_ack = 1'b1;
          if (dmem_we) dev_mem[dmem_addr] = dmem_wdata;
          else         dmem_rdata = dev_mem[dmem_addr];
        end else begin
          dmem_rdata = 8'($urandom);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: compares whenever the instruction in the stage leaves (stall low).
  initial begin
    exp_t       e;
    int         stall_seen = 0;
    logic [7:0] last_alu = 8'h00;
    logic [7:0] last_mem = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_seen = 0; last_alu = 8'h00; last_mem = 8'h00;
        continue;
      end
      if (dmem_req && sb.size() > 0 && sb[0].acc) begin
        check("dmem_addr", 32'(dmem_addr), 32'(sb[0].addr));
        check("dmem_we", 32'(dmem_we), 32'(sb[0].we));
        if (sb[0].we) check("dmem_wdata", 32'(dmem_wdata), 32'(sb[0].wdata));
      end
      if (stall) begin
        stall_seen++;
        check("pc_src_while_stalled", 32'(out_pc_src), 32'd0);
        if (stall_seen == 1) begin
          @(posedge clk); #2;
          if (rst_n) begin
            check("bubble_sig", 32'(out_WB_reg_write_signal), 32'd0);
            check("bubble_mor", 32'(out_WB_mem_or_alu), 32'd0);
            check("bubble_alu_hold", 32'(out_alu_result), 32'(last_alu));
            check("bubble_mdata_hold", 32'(out_mem_data), 32'(last_mem));
          end
        end
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_src", 32'(out_pc_src), 32'(e.pc_src));
        check("branch_pc", 32'(out_branch_pc), 32'(e.bpc));
        check("stall_cycles", 32'(stall_seen), 32'(e.stalls));
        stall_seen = 0;
        @(posedge clk); #2;
        check("alu_result", 32'(out_alu_result), 32'(e.alu));
        check("reg_write", 32'(out_reg_write), 32'(e.rd));
        check("wb_mem_or_alu", 32'(out_WB_mem_or_alu), 32'(e.mor));
        check("wb_reg_write_signal", 32'(out_WB_reg_write_signal), 32'(e.sig));
        check("mem_data", 32'(out_mem_data), 32'(e.mdata));
        check("mem_error", 32'(mem_error), 32'(e.err));
        last_alu = e.alu;
        last_mem = e.mdata;
      end else begin
        stall_seen = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      dev_mem[i] = v;
    end
    ref_mem[8'h10] = 8'hA5; dev_mem[8'h10] = 8'hA5;
    ref_mem[8'h40] = 8'h5A; dev_mem[8'h40] = 8'h5A;

    #12;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_alu", 32'(out_alu_result), 32'd0);
    check("rst_err", 32'(mem_error), 32'd0);
    @(negedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 3'd5, 1'b0, 1'b0, 12'h000, 0);
    issue(1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 3'd2, 1'b0, 1'b0, 12'h000, 2);
    issue(1'b1, 1'b0, 1'b0, 8'h22, 8'h7E, 3'd3, 1'b0, 1'b0, 12'h000, 1);
    issue(1'b0, 1'b1, 1'b1, 8'h30, 8'h00, 3'd4, 1'b0, 1'b0, 12'h000, 100);
    issue(1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 3'd1, 1'b1, 1'b1, 12'h0A4, 0);
    issue(1'b0, 1'b0, 1'b1, 8'h02, 8'h00, 3'd1, 1'b1, 1'b0, 12'h0B8, 0);
    issue(1'b0, 1'b1, 1'b1, 8'h22, 8'h00, 3'd6, 1'b1, 1'b1, 12'h0C0, 3);
    issue(1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 3'd7, 1'b0, 1'b0, 12'h000, T);

    for (int i = 0; i < 150; i++) begin
      int   kind;
      logic rw, mor;
      kind = $urandom_range(0, 2);
      rw   = (kind == 2);
      mor  = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom) : 1'b0;
      issue(rw, mor, 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 12'($urandom), $urandom_range(1, T + 1));
    end

    // Load left hanging in WAIT, then reset pulsed mid-cycle.
    in_MEM_mem_read_write = 1'b0; in_WB_mem_or_alu = 1'b1;
    in_WB_reg_write_signal = 1'b1; in_alu_result = 8'h55; in_reg_write = 3'd2;
    in_MEM_pc_src = 1'b1; in_zero = 1'b1; in_new_branch_pc = 12'h123;
    lat_q.push_back(100);
    repeat (3) @(negedge clk);
    check("wait_req_before_reset", 32'(dmem_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(dmem_req), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_pc_src", 32'(out_pc_src), 32'd0);
    check("arst_alu", 32'(out_alu_result), 32'd0);
    check("arst_rd", 32'(out_reg_write), 32'd0);
    check("arst_sig", 32'(out_WB_reg_write_signal), 32'd0);
    check("arst_mor", 32'(out_WB_mem_or_alu), 32'd0);
    check("arst_mdata", 32'(out_mem_data), 32'd0);
    check("arst_err", 32'(mem_error), 32'd0);
    sb.delete();
    lat_q.delete();
    mdl_mdata = 8'h00;
    mdl_err = 1'b0;
    set_nop();
    repeat (2) @(posedge clk);
    @(negedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 1'b1, 1'b1, 8'h40, 8'h00, 3'd3, 1'b0, 1'b0, 12'h000, 2);
    set_nop();
    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
